// File: rtl/btn_pkg.sv
// btn_pkg
// Shared definitions for the push-button conditioner and its consumers.
//   NBTN        : number of board buttons
//   btn_idx_e   : bit position of each button inside a button vector
//   btn_vec_t   : one bit per button
//   rpt_state_e : auto-repeat FSM states used by debounce_cell
//   maxOf       : elaboration-time helper for sizing counters
package btn_pkg;

    localparam int NBTN = 5;

    typedef enum logic [2:0] {
        BTN_L,
        BTN_R,
        BTN_U,
        BTN_D,
        BTN_C
    } btn_idx_e;

    typedef logic [NBTN-1:0] btn_vec_t;

    typedef enum logic {
        RPT_IDLE,
        RPT_HELD
    } rpt_state_e;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell
// Conditions one raw push-button: two-flop synchroniser, debounce counter
// and auto-repeat FSM. All outputs are registered.
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset
//   i_raw  : raw asynchronous button, active high
//   o_lvl  : debounced level
//   o_dn   : one-cycle pulse when o_lvl rises
//   o_up   : one-cycle pulse when o_lvl falls
//   o_rpt  : pulse at press, then after REPEAT_DELAY, then every REPEAT_PERIOD
module debounce_cell
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 400_000,
    parameter int REPEAT_DELAY    = 16_000_000,
    parameter int REPEAT_PERIOD   = 4_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_lvl,
    output logic o_dn,
    output logic o_up,
    output logic o_rpt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(maxOf(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DW-1:0] DLAST        = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RDELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    r_sync;
    logic [DW-1:0] r_dcnt;
    logic          r_lvl;
    logic          r_dn;
    logic          r_up;
    logic          r_rpt;
    logic [RW-1:0] r_rcnt;
    rpt_state_e    r_state;

    logic          w_differ;
    logic          w_accept;
    logic          w_rise;
    logic          w_fall;
    rpt_state_e    w_stateNxt;
    logic [RW-1:0] w_rcntNxt;
    logic          w_rptNxt;

    // The debounced level flips on the same edge the counter sees its last
    // disagreeing sample, so rise/fall are decoded combinationally here and
    // shared by the level register and the repeat FSM.
    assign w_differ = r_sync[1] != r_lvl;
    assign w_accept = w_differ && (r_dcnt == DLAST);
    assign w_rise   = w_accept && !r_lvl;
    assign w_fall   = w_accept && r_lvl;

    // Two-flop synchroniser; r_sync[1] is the sample the debouncer trusts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Debounce counter: any agreement with the current level restarts the
    // count, so only an unbroken run of DEBOUNCE_CYCLES samples is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt <= '0;
            r_lvl  <= 1'b0;
            r_dn   <= 1'b0;
            r_up   <= 1'b0;
        end else begin
            r_dn <= w_rise;
            r_up <= w_fall;
            if (!w_differ) begin
                r_dcnt <= '0;
            end else if (w_accept) begin
                r_dcnt <= '0;
                r_lvl  <= ~r_lvl;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    // Repeat FSM state register, countdown and registered repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RPT_IDLE;
            r_rcnt  <= '0;
            r_rpt   <= 1'b0;
        end else begin
            r_state <= w_stateNxt;
            r_rcnt  <= w_rcntNxt;
            r_rpt   <= w_rptNxt;
        end
    end

    // Next-state logic. In HELD an accepted release is checked before the
    // countdown so that a release landing on a repeat edge suppresses it.
    always_comb begin
        w_stateNxt = r_state;
        w_rcntNxt  = r_rcnt;
        w_rptNxt   = 1'b0;
        case (r_state)
            RPT_IDLE: begin
                if (w_rise) begin
                    w_stateNxt = RPT_HELD;
                    w_rcntNxt  = RDELAY_LOAD;
                    w_rptNxt   = 1'b1;
                end
            end
            RPT_HELD: begin
                if (w_fall) begin
                    w_stateNxt = RPT_IDLE;
                    w_rcntNxt  = '0;
                end else if (r_rcnt == '0) begin
                    w_rptNxt  = 1'b1;
                    w_rcntNxt = RPERIOD_LOAD;
                end else begin
                    w_rcntNxt = r_rcnt - 1'b1;
                end
            end
            default: begin
                w_stateNxt = RPT_IDLE;
                w_rcntNxt  = '0;
            end
        endcase
    end

    assign o_lvl = r_lvl;
    assign o_dn  = r_dn;
    assign o_up  = r_up;
    assign o_rpt = r_rpt;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Synchronises, debounces and auto-repeats the board push-buttons, one
// independent debounce_cell per button (bit order fixed by btn_pkg).
//   clk     : pixel clock, the only clock
//   rst_n   : asynchronous active-low reset
//   btn_raw : raw asynchronous buttons, active high
//   btn_lvl : debounced levels
//   btn_dn  : one-cycle press pulses
//   btn_up  : one-cycle release pulses
//   btn_rpt : auto-repeat pulses (one at press, more while held)
module btn_conditioner #(
    parameter int NBTN            = btn_pkg::NBTN,
    parameter int DEBOUNCE_CYCLES = 400_000,
    parameter int REPEAT_DELAY    = 16_000_000,
    parameter int REPEAT_PERIOD   = 4_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_lvl,
    output logic [NBTN-1:0] btn_dn,
    output logic [NBTN-1:0] btn_up,
    output logic [NBTN-1:0] btn_rpt
);

    // A zero count would make the counters meaningless, so refuse to build.
    if (DEBOUNCE_CYCLES < 1) begin : g_badDebounce
        $fatal(1, "btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_badDelay
        $fatal(1, "btn_conditioner: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_badPeriod
        $fatal(1, "btn_conditioner: REPEAT_PERIOD must be >= 1");
    end

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .i_raw (btn_raw[gi]),
            .o_lvl (btn_lvl[gi]),
            .o_dn  (btn_dn[gi]),
            .o_up  (btn_up[gi]),
            .o_rpt (btn_rpt[gi])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
// Directed scenarios plus randomized button activity against a behavioural
// model that works from sample histories and press timestamps.
module tb_btn_conditioner;

    localparam int N    = 5;
    localparam int D    = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXC = 16384;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_lvl;
    logic [N-1:0] btn_dn;
    logic [N-1:0] btn_up;
    logic [N-1:0] btn_rpt;

    int total = 0;
    int bad   = 0;

    btn_conditioner #(
        .NBTN            (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .btn_lvl (btn_lvl),
        .btn_dn  (btn_dn),
        .btn_up  (btn_up),
        .btn_rpt (btn_rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int           cyc = 0;
    logic [N-1:0] rawLog [MAXC];
    logic [N-1:0] exLog  [MAXC];
    logic [N-1:0] mLvl   = '0;
    logic [N-1:0] expLvl = '0;
    logic [N-1:0] expDn  = '0;
    logic [N-1:0] expUp  = '0;
    logic [N-1:0] expRpt = '0;
    int           lastEvt   [N];
    int           pressEdge [N];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input int n);
        btn_raw = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDn(input int b, input int limit, output int edgeNo);
        int n = 0;
        while (!btn_dn[b] && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("dnWait", 32'(btn_dn[b]), 32'd1);
        edgeNo = cyc;
    endtask

    // Model: the value examined at edge t is the raw level seen at edge t-2.
    // A level change happens when the last D examined samples all disagree
    // with the level and none of them predates the previous change/reset.
    // Repeat pulses follow from the press timestamp arithmetically.
    always @(posedge clk) begin
        bit allDiff;
        int k;
        cyc++;
        expDn = '0;
        expUp = '0;
        expRpt = '0;
        if (!rst_n) begin
            rawLog[cyc] = '0;
            exLog[cyc]  = '0;
            mLvl        = '0;
            for (int b = 0; b < N; b++) begin
                lastEvt[b]   = cyc;
                pressEdge[b] = -1;
            end
        end else begin
            rawLog[cyc] = btn_raw;
            exLog[cyc]  = (cyc >= 2) ? rawLog[cyc-2] : '0;
            for (int b = 0; b < N; b++) begin
                allDiff = (cyc - lastEvt[b]) >= D;
                for (int j = 0; j < D; j++) begin
                    if (allDiff && exLog[cyc-j][b] == mLvl[b]) allDiff = 1'b0;
                end
                if (allDiff) begin
                    if (!mLvl[b]) begin
                        expDn[b]     = 1'b1;
                        expRpt[b]    = 1'b1;
                        pressEdge[b] = cyc;
                    end else begin
                        expUp[b] = 1'b1;
                    end
                    mLvl[b]    = ~mLvl[b];
                    lastEvt[b] = cyc;
                end else if (mLvl[b]) begin
                    k = cyc - pressEdge[b];
                    expRpt[b] = (k >= RD) && ((k - RD) % RP == 0);
                end
            end
        end
        expLvl = mLvl;
    end

    // Every falling edge compares all outputs with the model, or with zero
    // while reset is asserted.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rstLvl", 32'(btn_lvl), 32'd0);
            checkOutput("rstPulses", 32'(btn_dn | btn_up | btn_rpt), 32'd0);
        end else begin
            checkOutput("lvl", 32'(btn_lvl), 32'(expLvl));
            checkOutput("dn", 32'(btn_dn), 32'(expDn));
            checkOutput("up", 32'(btn_up), 32'(expUp));
            checkOutput("rpt", 32'(btn_rpt), 32'(expRpt));
            checkOutput("dnUpExcl", 32'(btn_dn & btn_up), 32'd0);
        end
    end

    // Safety net so a stuck run still ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired total=%0d", total);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int           a;
        int           n;
        logic         sticky;
        logic [N-1:0] v;
        int           holdLeft [N];

        rst_n   = 1'b0;
        btn_raw = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetLvl", 32'(btn_lvl), 32'd0);
        checkOutput("resetDn", 32'(btn_dn), 32'd0);
        checkOutput("resetUp", 32'(btn_up), 32'd0);
        checkOutput("resetRpt", 32'(btn_rpt), 32'd0);
        rst_n = 1'b1;
        applyStimulus('0, 10);

        $display("[TB] clean press");
        applyStimulus(5'b00001, 5);
        checkOutput("pressEarly", 32'(btn_lvl[0]), 32'd0);
        applyStimulus(5'b00001, 1);
        checkOutput("pressLvl", 32'(btn_lvl[0]), 32'd1);
        checkOutput("pressDn", 32'(btn_dn[0]), 32'd1);
        checkOutput("pressRpt", 32'(btn_rpt[0]), 32'd1);
        checkOutput("pressUp", 32'(btn_up), 32'd0);
        applyStimulus(5'b00001, 1);
        checkOutput("pressDnOnce", 32'(btn_dn[0]), 32'd0);
        checkOutput("pressRptOnce", 32'(btn_rpt[0]), 32'd0);
        applyStimulus(5'b00001, 5);
        applyStimulus('0, 15);

        $display("[TB] bounce rejection");
        sticky = 1'b0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus((i < 40 && ((i / 2) % 2 == 0)) ? 5'b00100 : 5'b00000, 1);
            sticky = sticky | btn_lvl[2] | btn_dn[2] | btn_up[2];
        end
        checkOutput("bounce", 32'(sticky), 32'd0);

        $display("[TB] auto-repeat");
        btn_raw = 5'b10000;
        waitDn(4, 20, a);
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(5'b10000, 1);
            checkOutput("rpt4", 32'(btn_rpt[4]), 32'((k >= 10) && ((k - 10) % 3 == 0)));
        end
        applyStimulus('0, 5);
        checkOutput("up4Early", 32'(btn_up[4]), 32'd0);
        applyStimulus('0, 1);
        checkOutput("up4", 32'(btn_up[4]), 32'd1);
        checkOutput("up4Rpt", 32'(btn_rpt[4]), 32'd0);
        sticky = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus('0, 1);
            sticky = sticky | btn_rpt[4];
        end
        checkOutput("rpt4AfterUp", 32'(sticky), 32'd0);

        $display("[TB] release/repeat collision");
        btn_raw = 5'b00010;
        waitDn(1, 20, a);
        applyStimulus(5'b00010, 10);
        checkOutput("collRptA10", 32'(btn_rpt[1]), 32'd1);
        applyStimulus('0, 6);
        checkOutput("collUp", 32'(btn_up[1]), 32'd1);
        checkOutput("collRpt", 32'(btn_rpt[1]), 32'd0);
        sticky = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus('0, 1);
            sticky = sticky | btn_rpt[1];
        end
        checkOutput("collIdle", 32'(sticky), 32'd0);

        $display("[TB] async reset mid-hold");
        btn_raw = 5'b01000;
        waitDn(3, 20, a);
        applyStimulus(5'b01000, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncLvl", 32'(btn_lvl), 32'd0);
        checkOutput("asyncDn", 32'(btn_dn), 32'd0);
        checkOutput("asyncUp", 32'(btn_up), 32'd0);
        checkOutput("asyncRpt", 32'(btn_rpt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        n = 0;
        while (!btn_dn[3] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rstRepress", 32'(n), 32'd6);
        applyStimulus('0, 15);

        $display("[TB] multi-button");
        btn_raw = 5'b10011;
        n = 0;
        while (btn_dn == '0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("multiDn", 32'(btn_dn), 32'(5'b10011));
        checkOutput("multiLvl", 32'(btn_lvl), 32'(5'b10011));
        applyStimulus('0, 20);

        $display("[TB] random activity");
        v = '0;
        for (int b = 0; b < N; b++) holdLeft[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if (holdLeft[b] == 0) begin
                    v[b] = ~v[b];
                    holdLeft[b] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3))
                                                              : int'($urandom_range(5, 40));
                end else begin
                    holdLeft[b]--;
                end
            end
            applyStimulus(v, 1);
        end
        applyStimulus('0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
